// File: rtl/servo_sequencer.sv
// Four-channel servo position sequencer: per-frame sweep moves each enabled channel toward its target.
// Build option SERVO_SEQUENCER_RAMP_EN limits each frame's move to STEP codes; otherwise channels jump in one frame.
module servo_sequencer #(
    parameter int unsigned FRAME_CYCLES = 720000,
    parameter int unsigned STEP         = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_ch,
    input  logic [7:0]  cmd_pos,
    input  logic        cmd_off,
    output logic [3:0]  ch_enable,
    output logic [31:0] ch_data,
    output logic        frame_tick,
    output logic        settled
);

    localparam int unsigned CNT_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_CYCLES - 1);

`ifdef SERVO_SEQUENCER_RAMP_EN
    localparam logic [7:0] EFF_STEP = 8'(STEP);
`else
    // A full-scale step always covers the gap, collapsing the ramp into a one-frame jump.
    localparam logic [7:0] EFF_STEP = 8'(STEP) | 8'hFF;
`endif

    typedef enum logic {
        IDLE   = 1'b0,
        UPDATE = 1'b1
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [1:0]      slot_r;
    logic [1:0]      slot_s;
    logic [CNT_W-1:0] cnt_r;
    logic [3:0][7:0] tgt_r;
    logic [3:0][7:0] cur_r;
    logic [3:0]      en_r;
    logic            accept_s;
    logic [7:0]      sel_cur_s;
    logic [7:0]      sel_tgt_s;
    logic [7:0]      upd_pos_s;
    logic            settled_s;

    assign frame_tick = (cnt_r == LAST_CNT);
    assign cmd_ready  = ~rst & (state_r == IDLE) & ~frame_tick;
    assign accept_s   = cmd_valid & cmd_ready;
    assign ch_enable  = en_r;
    assign ch_data    = cur_r;
    assign settled    = settled_s;

    // Free-running frame counter, independent of the sequencer state.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (frame_tick) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    // Next-state logic: a frame boundary starts a four-slot sweep over channels 0..3.
    always_comb begin
        state_s = state_r;
        slot_s  = slot_r;
        case (state_r)
            IDLE: begin
                if (frame_tick) begin
                    state_s = UPDATE;
                    slot_s  = 2'd0;
                end else begin
                    state_s = IDLE;
                    slot_s  = 2'd0;
                end
            end
            UPDATE: begin
                if (slot_r == 2'd3) begin
                    state_s = IDLE;
                    slot_s  = 2'd0;
                end else begin
                    state_s = UPDATE;
                    slot_s  = slot_r + 2'd1;
                end
            end
            default: begin
                state_s = IDLE;
                slot_s  = 2'd0;
            end
        endcase
    end

    // Position step for the channel in the current slot; never wraps past 0 or 255.
    always_comb begin
        sel_cur_s = cur_r[slot_r];
        sel_tgt_s = tgt_r[slot_r];
        upd_pos_s = sel_cur_s;
        if (sel_tgt_s >= sel_cur_s) begin
            if ((sel_tgt_s - sel_cur_s) <= EFF_STEP) begin
                upd_pos_s = sel_tgt_s;
            end else begin
                upd_pos_s = sel_cur_s + EFF_STEP;
            end
        end else begin
            if ((sel_cur_s - sel_tgt_s) <= EFF_STEP) begin
                upd_pos_s = sel_tgt_s;
            end else begin
                upd_pos_s = sel_cur_s - EFF_STEP;
            end
        end
    end

    // Settled when every enabled channel has reached its target.
    always_comb begin
        settled_s = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (en_r[i] && (cur_r[i] != tgt_r[i])) begin
                settled_s = 1'b0;
            end else begin
                settled_s = settled_s;
            end
        end
    end

    // Sequencer state plus channel registers; commands only land in IDLE so they never collide with a slot update.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            slot_r  <= 2'd0;
            tgt_r   <= '0;
            cur_r   <= '0;
            en_r    <= 4'd0;
        end else begin
            state_r <= state_s;
            slot_r  <= slot_s;
            if ((state_r == UPDATE) && en_r[slot_r]) begin
                cur_r[slot_r] <= upd_pos_s;
            end
            if (accept_s) begin
                if (cmd_off) begin
                    en_r[cmd_ch] <= 1'b0;
                end else begin
                    tgt_r[cmd_ch] <= cmd_pos;
                    en_r[cmd_ch]  <= 1'b1;
                    if (!en_r[cmd_ch]) begin
                        cur_r[cmd_ch] <= cmd_pos;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_servo_sequencer.sv
// Self-checking bench for servo_sequencer: directed scenarios plus randomized commands
// checked against a cycle-indexed behavioural model of frames, sweeps and channel positions.
module tb_servo_sequencer;

    localparam int F    = 100;
    localparam int STEP = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_ch = 2'd0;
    logic [7:0]  cmd_pos = 8'd0;
    logic        cmd_off = 1'b0;
    logic [3:0]  ch_enable;
    logic [31:0] ch_data;
    logic        frame_tick;
    logic        settled;

    servo_sequencer #(.FRAME_CYCLES(F), .STEP(STEP)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ch(cmd_ch), .cmd_pos(cmd_pos), .cmd_off(cmd_off),
        .ch_enable(ch_enable), .ch_data(ch_data), .frame_tick(frame_tick), .settled(settled)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model: cycle index since reset, targets, currents, enables.
    int m_tgt[4];
    int m_cur[4];
    bit m_en[4];
    int cyc = 0;
    bit ramp;
    bit exp_ready, obs_ready, exp_tick, obs_tick;

    function automatic int move_toward(int c, int t);
        int s;
        int d;
        s = ramp ? STEP : 255;
        d = t - c;
        if (d <= s && d >= -s) return t;
        if (d > 0) return c + s;
        return c - s;
    endfunction

    function automatic logic [31:0] exp_data();
        logic [31:0] v;
        for (int i = 0; i < 4; i++) v[8*i +: 8] = 8'(m_cur[i]);
        return v;
    endfunction

    function automatic logic [3:0] exp_en();
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = m_en[i];
        return v;
    endfunction

    function automatic logic exp_settled();
        for (int i = 0; i < 4; i++) if (m_en[i] && m_cur[i] != m_tgt[i]) return 1'b0;
        return 1'b1;
    endfunction

    // One clock cycle: drive inputs at the falling edge, sample, advance the model at the rising edge.
    task automatic step(bit r, bit v, int ch, int pos, bit off);
        int p;
        bit upd;
        rst = r; cmd_valid = v; cmd_ch = 2'(ch); cmd_pos = 8'(pos); cmd_off = off;
        #1;
        obs_ready = cmd_ready;
        obs_tick  = frame_tick;
        p         = cyc % F;
        upd       = (cyc >= F) && (p < 4);
        exp_tick  = (p == F - 1);
        exp_ready = !r && !exp_tick && !upd;
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 4; i++) begin m_tgt[i] = 0; m_cur[i] = 0; m_en[i] = 0; end
            cyc = 0;
        end else begin
            if (upd && m_en[p]) m_cur[p] = move_toward(m_cur[p], m_tgt[p]);
            if (v && exp_ready) begin
                if (off) m_en[ch] = 0;
                else begin
                    if (!m_en[ch]) m_cur[ch] = pos;
                    m_tgt[ch] = pos;
                    m_en[ch]  = 1;
                end
            end
            cyc++;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic wait_idle();
        while ((cyc % F) < 5 || (cyc % F) > F - 10) idle();
    endtask

    task automatic run_to_after_update();
        do idle(); while (!(cyc >= F && (cyc % F) == 4));
    endtask

    task automatic test_reset();
        repeat (3) step(1'b1, 1'b0, 0, 0, 1'b0);
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %0b want 0", cmd_ready); end
        checks++; if (ch_enable !== 4'd0) begin errors++; $display("FAIL reset_enable got %h want 0", ch_enable); end
        checks++; if (ch_data !== 32'd0) begin errors++; $display("FAIL reset_data got %h want 0", ch_data); end
        checks++; if (settled !== 1'b1) begin errors++; $display("FAIL reset_settled got %0b want 1", settled); end
        checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %0b want 0", frame_tick); end
        idle();
        checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL release_ready got %0b want 1", obs_ready); end
    endtask

    task automatic test_frame_tick();
        int ticks[$];
        int want[3] = '{99, 199, 299};
        int cb;
        while (cyc < 3 * F + 2) begin
            cb = cyc;
            idle();
            checks++; if (obs_tick !== exp_tick) begin errors++; $display("FAIL tick_cycle %0d got %0b want %0b", cb, obs_tick, exp_tick); end
            if (obs_tick === 1'b1) ticks.push_back(cb);
        end
        checks++; if (ticks.size() != 3) begin errors++; $display("FAIL tick_count got %0d want 3", ticks.size()); end
        for (int k = 0; k < 3 && k < ticks.size(); k++) begin
            checks++; if (ticks[k] != want[k]) begin errors++; $display("FAIL tick_pos%0d got %0d want %0d", k, ticks[k], want[k]); end
        end
        checks++; if (ch_enable !== 4'd0 || ch_data !== 32'd0 || settled !== 1'b1) begin
            errors++; $display("FAIL tick_idle_outputs got en=%h data=%h set=%0b want 0 0 1", ch_enable, ch_data, settled);
        end
    endtask

    task automatic test_ramp();
        int want_pos[3];
        bit want_set[3];
        want_pos = ramp ? '{24, 28, 30} : '{30, 30, 30};
        want_set = ramp ? '{1'b0, 1'b0, 1'b1} : '{1'b1, 1'b1, 1'b1};
        wait_idle();
        step(1'b0, 1'b1, 0, 20, 1'b0);
        checks++; if (ch_enable[0] !== 1'b1 || ch_data[7:0] !== 8'd20) begin
            errors++; $display("FAIL first_enable got en=%0b pos=%0d want 1 20", ch_enable[0], ch_data[7:0]);
        end
        step(1'b0, 1'b1, 0, 30, 1'b0);
        checks++; if (ch_data[7:0] !== 8'd20 || settled !== 1'b0) begin
            errors++; $display("FAIL retarget_hold got pos=%0d set=%0b want 20 0", ch_data[7:0], settled);
        end
        for (int k = 0; k < 3; k++) begin
            run_to_after_update();
            checks++; if (ch_data[7:0] !== 8'(want_pos[k])) begin errors++; $display("FAIL ramp_frame%0d got %0d want %0d", k, ch_data[7:0], want_pos[k]); end
            checks++; if (settled !== want_set[k]) begin errors++; $display("FAIL ramp_settled%0d got %0b want %0b", k, settled, want_set[k]); end
        end
    endtask

    task automatic test_bounds();
        wait_idle();
        step(1'b0, 1'b1, 2, 2, 1'b0);
        step(1'b0, 1'b1, 2, 0, 1'b0);
        step(1'b0, 1'b1, 3, 253, 1'b0);
        step(1'b0, 1'b1, 3, 255, 1'b0);
        run_to_after_update();
        checks++; if (ch_data[23:16] !== 8'd0) begin errors++; $display("FAIL underflow got %0d want 0", ch_data[23:16]); end
        checks++; if (ch_data[31:24] !== 8'd255) begin errors++; $display("FAIL overflow got %0d want 255", ch_data[31:24]); end
        checks++; if (settled !== 1'b1) begin errors++; $display("FAIL bounds_settled got %0b want 1", settled); end
    endtask

    task automatic test_back_to_back();
        int lows = 0;
        bit got = 0;
        while ((cyc % F) != F - 1) idle();
        for (int n = 0; n < 20 && !got; n++) begin
            step(1'b0, 1'b1, 1, 77, 1'b0);
            if (obs_ready === 1'b1) got = 1; else lows++;
        end
        idle();
        checks++; if (!got) begin errors++; $display("FAIL hold_accept got none want one"); end
        checks++; if (lows != 5) begin errors++; $display("FAIL hold_low_cycles got %0d want 5", lows); end
        checks++; if (ch_enable[1] !== 1'b1 || ch_data[15:8] !== 8'd77) begin
            errors++; $display("FAIL hold_write got en=%0b pos=%0d want 1 77", ch_enable[1], ch_data[15:8]);
        end
    endtask

    task automatic test_off();
        logic [7:0] frozen;
        wait_idle();
        step(1'b0, 1'b1, 1, 200, 1'b0);
        run_to_after_update();
        checks++; if (ch_data[15:8] !== (ramp ? 8'd81 : 8'd200)) begin
            errors++; $display("FAIL off_pre_ramp got %0d want %0d", ch_data[15:8], ramp ? 81 : 200);
        end
        wait_idle();
        step(1'b0, 1'b1, 1, 9, 1'b1);
        checks++; if (ch_enable !== 4'b1101) begin errors++; $display("FAIL off_enable got %b want 1101", ch_enable); end
        frozen = ch_data[15:8];
        run_to_after_update();
        run_to_after_update();
        checks++; if (ch_data[15:8] !== frozen) begin errors++; $display("FAIL off_frozen got %0d want %0d", ch_data[15:8], frozen); end
        checks++; if (settled !== 1'b1) begin errors++; $display("FAIL off_settled got %0b want 1", settled); end
    endtask

    task automatic test_reset_mid_update();
        wait_idle();
        step(1'b0, 1'b1, 0, 0, 1'b1);
        step(1'b0, 1'b1, 0, 10, 1'b0);
        step(1'b0, 1'b1, 0, 200, 1'b0);
        run_to_after_update();
        checks++; if (ch_data[7:0] !== (ramp ? 8'd14 : 8'd200)) begin
            errors++; $display("FAIL jump got %0d want %0d", ch_data[7:0], ramp ? 14 : 200);
        end
        while (!(cyc >= F && (cyc % F) == 1)) idle();
        step(1'b1, 1'b0, 0, 0, 1'b0);
        checks++; if (ch_enable !== 4'd0 || ch_data !== 32'd0 || cmd_ready !== 1'b0 || frame_tick !== 1'b0 || settled !== 1'b1) begin
            errors++; $display("FAIL mid_reset got en=%h data=%h rdy=%0b tick=%0b set=%0b want 0 0 0 0 1",
                               ch_enable, ch_data, cmd_ready, frame_tick, settled);
        end
        idle();
        checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL mid_release_ready got %0b want 1", obs_ready); end
    endtask

    task automatic test_random();
        int pos;
        int edge_pos[6] = '{0, 1, 2, 253, 254, 255};
        for (int n = 0; n < 2000; n++) begin
            pos = ($urandom_range(0, 3) == 0) ? edge_pos[$urandom_range(0, 5)] : int'($urandom_range(0, 255));
            step(1'b0, $urandom_range(0, 7) == 0, int'($urandom_range(0, 3)), pos, $urandom_range(0, 5) == 0);
            checks++; if (obs_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready cyc %0d got %0b want %0b", cyc, obs_ready, exp_ready); end
            checks++; if (obs_tick !== exp_tick) begin errors++; $display("FAIL rnd_tick cyc %0d got %0b want %0b", cyc, obs_tick, exp_tick); end
            checks++; if (ch_enable !== exp_en()) begin errors++; $display("FAIL rnd_enable cyc %0d got %b want %b", cyc, ch_enable, exp_en()); end
            checks++; if (ch_data !== exp_data()) begin errors++; $display("FAIL rnd_data cyc %0d got %h want %h", cyc, ch_data, exp_data()); end
            checks++; if (settled !== exp_settled()) begin errors++; $display("FAIL rnd_settled cyc %0d got %0b want %0b", cyc, settled, exp_settled()); end
        end
    endtask

    initial begin
`ifdef SERVO_SEQUENCER_RAMP_EN
        ramp = 1'b1;
`else
        ramp = 1'b0;
`endif
        @(negedge clk);
        test_reset();
        test_frame_tick();
        test_ramp();
        test_bounds();
        test_back_to_back();
        test_off();
        test_reset_mid_update();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
